// File: rtl/video_timing_meas.sv
// video_timing_meas: measures the raster timing of an hs/vs/de stream
// (totals, sync widths, porches, active sizes, vs-to-hs offset) and
// reports lock/loss so downstream logic knows when the numbers are stable.
module video_timing_meas #(
  parameter int X_BITS      = 12,
  parameter int Y_BITS      = 12,
  parameter int LOCK_FRAMES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce_pix,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              de_in,
  output logic [X_BITS-1:0] h_total,
  output logic [X_BITS-1:0] h_sync,
  output logic [X_BITS-1:0] h_bp,
  output logic [X_BITS-1:0] h_active,
  output logic [X_BITS-1:0] h_fp,
  output logic [X_BITS-1:0] hv_offset,
  output logic [Y_BITS-1:0] v_total,
  output logic [Y_BITS-1:0] v_sync,
  output logic [Y_BITS-1:0] v_bp,
  output logic [Y_BITS-1:0] v_active,
  output logic [Y_BITS-1:0] v_fp,
  output logic              valid,
  output logic              changed
);

  typedef struct packed {
    logic [X_BITS-1:0] h_total, h_sync, h_bp, h_active, h_fp, hv_offset;
    logic [Y_BITS-1:0] v_total, v_sync, v_bp, v_active, v_fp;
  } timing_t;

  localparam logic [X_BITS-1:0] X_MAX  = '1;
  localparam logic [Y_BITS-1:0] Y_MAX  = '1;
  localparam logic [X_BITS-1:0] X_ONE  = X_BITS'(1);
  localparam logic [Y_BITS-1:0] Y_ONE  = Y_BITS'(1);
  localparam logic [3:0]        LOCK_N = 4'(LOCK_FRAMES);

  logic              hs_d, vs_d, de_d;
  logic [X_BITS-1:0] hpos, pos;
  logic [Y_BITS-1:0] vcnt, vcnt_next, line;
  logic              hs_rise, hs_fall, vs_rise, vs_fall, de_rise, de_fall;
  logic              lost, started, de_seen;

  // per-line captures; sh_h_sync_ln is the line in progress, sh_h_sync the last complete one
  logic [X_BITS-1:0] sh_h_total, sh_h_sync, sh_h_sync_ln, sh_de_start, sh_h_bp, sh_h_active;
  logic [X_BITS-1:0] h_sync_cur;
  logic [Y_BITS-1:0] sh_v_sync, de_first, de_last;

  logic [X_BITS-1:0] h_tot_now, h_syn_now, h_bp_now, h_act_now;
  logic [Y_BITS-1:0] v_bp_now, v_act_now;
  timing_t           nxt, pub;
  logic [3:0]        match_cnt;

  assign hs_rise = ce_pix &  hs_in & ~hs_d;
  assign hs_fall = ce_pix & ~hs_in &  hs_d;
  assign vs_rise = ce_pix &  vs_in & ~vs_d;
  assign vs_fall = ce_pix & ~vs_in &  vs_d;
  assign de_rise = ce_pix &  de_in & ~de_d;
  assign de_fall = ce_pix & ~de_in &  de_d;

  // position of the current ce_pix cycle within the line / frame
  assign pos        = hs_rise ? '0 : ((hpos == X_MAX) ? hpos : hpos + X_ONE);
  assign vcnt_next  = (hs_rise && vcnt != Y_MAX) ? vcnt + Y_ONE : vcnt;
  assign line       = vs_rise ? '0 : vcnt_next;
  assign h_sync_cur = hs_fall ? pos : sh_h_sync_ln;
  assign lost       = (pos == X_MAX) | (~vs_rise & (vcnt_next == Y_MAX));

  // candidate frame record; de-derived fields are zero for a frame without de
  assign h_tot_now = hs_rise ? hpos + X_ONE : sh_h_total;
  assign h_syn_now = hs_rise ? sh_h_sync_ln : sh_h_sync;
  assign h_bp_now  = de_seen ? sh_h_bp : '0;
  assign h_act_now = de_seen ? sh_h_active : '0;
  assign v_bp_now  = de_seen ? de_first - sh_v_sync : '0;
  assign v_act_now = de_seen ? de_last - de_first + Y_ONE : '0;
  assign nxt = '{h_total:   h_tot_now,
                 h_sync:    h_syn_now,
                 h_bp:      h_bp_now,
                 h_active:  h_act_now,
                 h_fp:      h_tot_now - h_syn_now - h_bp_now - h_act_now,
                 hv_offset: pos,
                 v_total:   vcnt_next,
                 v_sync:    sh_v_sync,
                 v_bp:      v_bp_now,
                 v_active:  v_act_now,
                 v_fp:      vcnt_next - sh_v_sync - v_bp_now - v_act_now};

  // edge history, position counters and shadow captures, all gated by ce_pix
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_d         <= 1'b0;
      vs_d         <= 1'b0;
      de_d         <= 1'b0;
      hpos         <= '0;
      vcnt         <= '0;
      sh_h_total   <= '0;
      sh_h_sync    <= '0;
      sh_h_sync_ln <= '0;
      sh_de_start  <= '0;
      sh_h_bp      <= '0;
      sh_h_active  <= '0;
      sh_v_sync    <= '0;
      de_first     <= '0;
      de_last      <= '0;
      de_seen      <= 1'b0;
      started      <= 1'b0;
    end else if (ce_pix) begin
      hs_d <= hs_in;
      vs_d <= vs_in;
      de_d <= de_in;
      hpos <= pos;
      vcnt <= vs_rise ? '0 : vcnt_next;
      if (hs_rise) begin
        sh_h_total <= hpos + X_ONE;
        sh_h_sync  <= sh_h_sync_ln;
      end
      if (hs_fall) sh_h_sync_ln <= pos;
      if (de_rise) begin
        sh_de_start <= pos;
        sh_h_bp     <= pos - h_sync_cur;
        if (!de_seen || vs_rise) de_first <= line;
        de_last <= line;
      end
      if (de_fall) sh_h_active <= pos - sh_de_start;
      if (vs_fall) sh_v_sync <= vcnt_next;
      if (vs_rise) started <= 1'b1;
      de_seen <= de_rise | (de_seen & ~vs_rise);
    end
  end

  // publish on vs rise, track consecutive identical frames, clear lock on loss
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pub       <= '0;
      match_cnt <= '0;
      changed   <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (ce_pix) begin
        if (vs_rise && started) begin
          pub <= nxt;
          if (nxt != pub) begin
            changed   <= 1'b1;
            match_cnt <= '0;
          end else if (match_cnt != LOCK_N) begin
            match_cnt <= match_cnt + 4'd1;
          end
        end
        if (lost) match_cnt <= '0;
      end
    end
  end

  assign valid     = (match_cnt == LOCK_N);
  assign h_total   = pub.h_total;
  assign h_sync    = pub.h_sync;
  assign h_bp      = pub.h_bp;
  assign h_active  = pub.h_active;
  assign h_fp      = pub.h_fp;
  assign hv_offset = pub.hv_offset;
  assign v_total   = pub.v_total;
  assign v_sync    = pub.v_sync;
  assign v_bp      = pub.v_bp;
  assign v_active  = pub.v_active;
  assign v_fp      = pub.v_fp;

endmodule

// File: tb/tb_video_timing_meas.sv
// Bench for video_timing_meas: a raster generator drives frames from
// parameter sets; a frame-level model predicts what each vs rise publishes.
module tb_video_timing_meas;
  localparam int L = 2;

  logic clk = 1'b0, reset_n = 1'b0, ce_pix = 1'b0;
  logic hs_in = 1'b0, vs_in = 1'b0, de_in = 1'b0;
  logic [11:0] h_total, h_sync, h_bp, h_active, h_fp, hv_offset;
  logic [11:0] v_total, v_sync, v_bp, v_active, v_fp;
  logic valid, changed;

  typedef struct { int hsync, hbp, hact, hfp, vsync, vbp, vact, vfp, off; } tim_t;
  typedef struct packed { int ht, hs, hb, ha, hf, hv, vt, vs, vb, va, vf; } meas_t;

  int    checks = 0, failures = 0, chg_cnt = 0;
  bit    chk_en = 1'b0;
  meas_t exp_pub = '0;
  bit    exp_chg = 1'b0;
  int    m_match = 0;
  bit    m_started = 1'b0;
  tim_t  m_prev;

  video_timing_meas #(.X_BITS(12), .Y_BITS(12), .LOCK_FRAMES(L)) dut (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix),
    .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
    .h_total(h_total), .h_sync(h_sync), .h_bp(h_bp), .h_active(h_active),
    .h_fp(h_fp), .hv_offset(hv_offset),
    .v_total(v_total), .v_sync(v_sync), .v_bp(v_bp), .v_active(v_active), .v_fp(v_fp),
    .valid(valid), .changed(changed)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // what a vs rise must publish, given the frame that just ended and the new offset
  function automatic meas_t frame_meas(input tim_t p, input int off_c);
    meas_t m;
    int hh, vv;
    hh = p.hsync + p.hbp + p.hact + p.hfp;
    vv = p.vsync + p.vbp + p.vact + p.vfp;
    m.ht = hh; m.hs = p.hsync; m.hv = off_c; m.vt = vv; m.vs = p.vsync;
    if (p.vact > 0) begin
      m.hb = p.hbp; m.ha = p.hact; m.hf = p.hfp;
      m.vb = p.vbp; m.va = p.vact; m.vf = p.vfp;
    end else begin
      m.hb = 0; m.ha = 0; m.hf = hh - p.hsync;
      m.vb = 0; m.va = 0; m.vf = vv - p.vsync;
    end
    return m;
  endfunction

  // per-cycle comparison of everything the DUT reports
  always @(negedge clk) begin
    if (reset_n && changed) chg_cnt++;
    if (chk_en) begin
      chk("h_total",   int'(h_total),   exp_pub.ht);
      chk("h_sync",    int'(h_sync),    exp_pub.hs);
      chk("h_bp",      int'(h_bp),      exp_pub.hb);
      chk("h_active",  int'(h_active),  exp_pub.ha);
      chk("h_fp",      int'(h_fp),      exp_pub.hf);
      chk("hv_offset", int'(hv_offset), exp_pub.hv);
      chk("v_total",   int'(v_total),   exp_pub.vt);
      chk("v_sync",    int'(v_sync),    exp_pub.vs);
      chk("v_bp",      int'(v_bp),      exp_pub.vb);
      chk("v_active",  int'(v_active),  exp_pub.va);
      chk("v_fp",      int'(v_fp),      exp_pub.vf);
      chk("valid",     int'(valid),     int'(m_match == L));
      chk("changed",   int'(changed),   int'(exp_chg));
    end
  end

  task automatic pix(input logic h, input logic v, input logic d, input bit pb,
                     input tim_t t, input int gm);
    meas_t n;
    int gap;
    hs_in = h; vs_in = v; de_in = d; ce_pix = 1'b1;
    @(posedge clk);
    exp_chg = 1'b0;
    if (pb) begin
      if (m_started) begin
        n = frame_meas(m_prev, t.off);
        if (n != exp_pub) begin
          exp_chg = 1'b1;
          m_match = 0;
        end else if (m_match < L) begin
          m_match++;
        end
        exp_pub = n;
      end
      m_started = 1'b1;
      m_prev = t;
    end
    @(negedge clk);
    gap = (gm == 1) ? 1 : (gm == 2) ? int'($urandom_range(0, 2)) : 0;
    repeat (gap) begin
      ce_pix = 1'b0;
      @(posedge clk);
      exp_chg = 1'b0;
      @(negedge clk);
    end
  endtask

  // one frame of raster; stop_at >= 0 truncates after that many pixels
  task automatic run_frame(input tim_t t, input int gm, input int stop_at);
    int hh, vv, n;
    logic h, v, d;
    hh = t.hsync + t.hbp + t.hact + t.hfp;
    vv = t.vsync + t.vbp + t.vact + t.vfp;
    n = 0;
    for (int l = 0; l < vv; l++) begin
      for (int p = 0; p < hh; p++) begin
        if (stop_at >= 0 && n == stop_at) return;
        h = (p < t.hsync);
        v = (l > 0 || p >= t.off) && (l < t.vsync || (l == t.vsync && p < t.off));
        d = (l >= t.vsync + t.vbp) && (l < t.vsync + t.vbp + t.vact) &&
            (p >= t.hsync + t.hbp) && (p < t.hsync + t.hbp + t.hact);
        pix(h, v, d, (l == 0 && p == t.off), t, gm);
        n++;
      end
    end
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    ce_pix = 1'b0; hs_in = 1'b0; vs_in = 1'b0; de_in = 1'b0;
    reset_n = 1'b0;
    exp_pub = '0; exp_chg = 1'b0; m_match = 0; m_started = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk_en = 1'b1;
  endtask

  tim_t p0, p1, pn, r;
  int   c0, hh;

  initial begin
    p0 = '{hsync:2, hbp:3, hact:12, hfp:3, vsync:1, vbp:2, vact:6, vfp:1, off:0};
    p1 = p0; p1.hact = 10; p1.hfp = 5;
    pn = '{hsync:2, hbp:3, hact:12, hfp:3, vsync:1, vbp:0, vact:0, vfp:9, off:0};

    // reset state
    do_reset();
    @(negedge clk);
    chk("rst_valid", int'(valid), 0);
    chk("rst_h_total", int'(h_total), 0);

    // nominal timing, continuous ce
    c0 = chg_cnt;
    repeat (4) run_frame(p0, 0, -1);
    chk("A_h_total", int'(h_total), 20);
    chk("A_h_bp", int'(h_bp), 3);
    chk("A_h_fp", int'(h_fp), 3);
    chk("A_v_total", int'(v_total), 10);
    chk("A_v_active", int'(v_active), 6);
    chk("A_valid", int'(valid), 1);
    chk("A_changed_cnt", chg_cnt - c0, 1);

    // mid-stream mode switch
    repeat (4) run_frame(p1, 0, -1);
    chk("S_h_active", int'(h_active), 10);
    chk("S_h_fp", int'(h_fp), 5);
    chk("S_valid", int'(valid), 1);
    chk("S_changed_cnt", chg_cnt - c0, 2);

    // asynchronous reset mid-line while locked
    run_frame(p1, 0, 45);
    chk_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("R_h_total", int'(h_total), 0);
    chk("R_v_total", int'(v_total), 0);
    chk("R_valid", int'(valid), 0);
    do_reset();

    // offset vs and half-rate pixel enable
    p0.off = 7;
    c0 = chg_cnt;
    repeat (4) run_frame(p0, 1, -1);
    chk("B_hv_offset", int'(hv_offset), 7);
    chk("B_v_sync", int'(v_sync), 1);
    chk("B_v_total", int'(v_total), 10);
    chk("B_valid", int'(valid), 1);
    chk("B_changed_cnt", chg_cnt - c0, 1);

    // hs stops: lock lost, outputs hold
    chk_en = 1'b0;
    repeat (4100) pix(1'b0, 1'b0, 1'b0, 1'b0, p0, 0);
    chk("X_valid", int'(valid), 0);
    chk("X_h_total", int'(h_total), 20);
    chk("X_hv_offset", int'(hv_offset), 7);
    chk("X_h_active", int'(h_active), 12);
    do_reset();

    // no data enable at all
    repeat (3) run_frame(pn, 0, -1);
    chk("N_v_active", int'(v_active), 0);
    chk("N_v_bp", int'(v_bp), 0);
    chk("N_v_fp", int'(v_fp), 9);
    chk("N_h_active", int'(h_active), 0);
    chk("N_v_total", int'(v_total), 10);

    // randomized timings, offsets and pixel-enable gaps
    do_reset();
    for (int s = 0; s < 8; s++) begin
      r.hsync = $urandom_range(1, 3);
      r.hbp   = $urandom_range(1, 4);
      r.hact  = $urandom_range(1, 12);
      r.hfp   = $urandom_range(1, 5);
      r.vsync = $urandom_range(1, 2);
      r.vbp   = $urandom_range(1, 3);
      r.vact  = $urandom_range(0, 5);
      r.vfp   = $urandom_range(1, 3);
      hh      = r.hsync + r.hbp + r.hact + r.hfp;
      r.off   = $urandom_range(0, hh - 1);
      repeat ($urandom_range(1, 3)) run_frame(r, $urandom_range(0, 2), -1);
    end
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
